// File: rtl/mult_arbiter_if.sv
// Handshake bundle between the two clients, the response consumer, the shared
// multiplier and mult_arbiter. The arbiter connects through the slave modport.
interface mult_arbiter_if #(
  parameter int N = 5
);
  logic           req0_valid;
  logic [N-1:0]   req0_a;
  logic [N-1:0]   req0_b;
  logic           req0_ready;
  logic           req1_valid;
  logic [N-1:0]   req1_a;
  logic [N-1:0]   req1_b;
  logic           req1_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [2*N-1:0] rsp_data;
  logic           rsp_err;
  logic [N-1:0]   mul_a;
  logic [N-1:0]   mul_b;
  logic           mul_start;
  logic [2*N-1:0] mul_out;
  logic           mul_finish;
  logic           busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp_ready, mul_out, mul_finish,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    output mul_a, mul_b, mul_start, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp_ready, mul_out, mul_finish,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
    input  mul_a, mul_b, mul_start, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer for two clients sharing one shift-add multiplier.
// Runs one operation at a time with a RUN-phase timeout and a tagged response.
module mult_arbiter #(
  parameter int N       = 5,
  parameter int TIMEOUT = N + 4
) (
  input logic           clk,
  input logic           reset,
  mult_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mul_a_q, mul_a_d;
  logic [N-1:0]   mul_b_q, mul_b_d;
  logic           rsp_id_q, rsp_id_d;
  logic [2*N-1:0] rsp_data_q, rsp_data_d;
  logic           rsp_err_q, rsp_err_d;
  logic           any_valid;
  logic           grant_id;

  // On a tie the requester that was not served last wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_q;
    end else begin
      grant_id = bus.req1_valid;
    end
  end

  assign bus.req0_ready = (state_q == IDLE) && any_valid && !grant_id;
  assign bus.req1_ready = (state_q == IDLE) && any_valid && grant_id;
  assign bus.mul_start  = (state_q == RUN);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.busy       = (state_q != IDLE);
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d  = LOAD;
          mul_a_d  = grant_id ? bus.req1_a : bus.req0_a;
          mul_b_d  = grant_id ? bus.req1_b : bus.req0_b;
          rsp_id_d = grant_id;
          last_d   = grant_id;
          cnt_d    = '0;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        // A finish seen in the last allowed cycle still wins over the timeout.
        cnt_d = cnt_q + CW'(1);
        if (bus.mul_finish) begin
          rsp_data_d = bus.mul_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
endmodule
